// File: rtl/dds_cmd_pkg.sv
// Shared constants for the DDS command scheduler: command/status codes,
// frame field offsets within the 88-bit frame, and the scheduler FSM encoding.
package dds_cmd_pkg;

  localparam logic [7:0] CMD_WR_ALL   = 8'h01;
  localparam logic [7:0] CMD_WR_FWORD = 8'h02;
  localparam logic [7:0] CMD_WR_OUTEN = 8'h03;
  localparam logic [7:0] CMD_QUERY    = 8'h04;

  localparam logic [7:0] STAT_ACK     = 8'hA5;
  localparam logic [7:0] STAT_BAD_CMD = 8'hE0;
  localparam logic [7:0] STAT_BAD_CH  = 8'hE1;
  localparam logic [7:0] STAT_BUSY_TO = 8'hE2;
  localparam logic [7:0] STAT_OVF     = 8'hE3;

  // rev_data0 occupies the top byte, rev_data10 the bottom byte
  localparam int FRAME_W   = 88;
  localparam int CMD_OFS   = 80;
  localparam int CH_OFS    = 72;
  localparam int FWORD_OFS = 40;
  localparam int PWORD_OFS = 24;
  localparam int AMP_OFS   = 16;
  localparam int OUTEN_OFS = 15;
  localparam int WAVE_OFS  = 8;
  localparam int TAG_OFS   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_DDS,
    ST_LOAD,
    ST_TX0,
    ST_TX0_W,
    ST_TX1,
    ST_TX1_W
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DATA_W     = 88,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dds_cmd_sched.sv
// Command scheduler: queues received frames, applies each to a DDS channel via
// a busy-aware load handshake, and answers every command with a status/tag reply.
module dds_cmd_sched
  import dds_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 50000,
  parameter int NUM_CH       = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        recv_done,
  input  logic [7:0]                  rev_data0,
  input  logic [7:0]                  rev_data1,
  input  logic [7:0]                  rev_data2,
  input  logic [7:0]                  rev_data3,
  input  logic [7:0]                  rev_data4,
  input  logic [7:0]                  rev_data5,
  input  logic [7:0]                  rev_data6,
  input  logic [7:0]                  rev_data7,
  input  logic [7:0]                  rev_data8,
  input  logic [7:0]                  rev_data9,
  input  logic [7:0]                  rev_data10,
  output logic                        cfg_ch,
  output logic [31:0]                 cfg_fword,
  output logic [11:0]                 cfg_pword,
  output logic [7:0]                  cfg_amp,
  output logic [1:0]                  cfg_wave,
  output logic                        cfg_out_en,
  output logic                        cfg_load,
  input  logic                        dds_busy,
  output logic [7:0]                  tx_data,
  output logic                        tx_en,
  input  logic                        tx_busy,
  output logic [7:0]                  ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_lvl
);

  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] frame_in, fifo_dout, cmd_q;
  logic               fifo_full, fifo_empty;
  logic               pop, drop;
  logic               reply_set, nak_take, do_load, do_tx, cnt_clr, cnt_inc;
  logic [7:0]         status_q, tag_q, status_nxt, tag_nxt;
  logic               nak_pend;
  logic [7:0]         nak_tag;
  logic [CNT_W-1:0]   to_cnt;
  logic               tx_seen;

  logic [7:0]  f_cmd, f_chb, f_tag, f_amp;
  logic        f_ch, f_out_en, bad_cmd, bad_ch;
  logic [31:0] f_fword;
  logic [11:0] f_pword;
  logic [1:0]  f_wave;
  logic        unused_bits;

  logic [31:0] sh_fword [NUM_CH];
  logic [11:0] sh_pword [NUM_CH];
  logic [7:0]  sh_amp   [NUM_CH];
  logic [1:0]  sh_wave  [NUM_CH];
  logic        sh_en    [NUM_CH];

  logic [31:0] ld_fword;
  logic [11:0] ld_pword;
  logic [7:0]  ld_amp;
  logic [1:0]  ld_wave;
  logic        ld_en;

  assign frame_in = {rev_data0, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
                     rev_data6, rev_data7, rev_data8, rev_data9, rev_data10};

  cmd_fifo #(
    .DATA_W     (FRAME_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst_n),
    .push  (recv_done),
    .pop   (pop),
    .din   (frame_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // A full FIFO still takes the frame if the scheduler pops in the same cycle
  assign drop = recv_done && fifo_full && !pop;

  assign f_cmd       = cmd_q[CMD_OFS +: 8];
  assign f_chb       = cmd_q[CH_OFS +: 8];
  assign f_ch        = cmd_q[CH_OFS];
  assign f_fword     = cmd_q[FWORD_OFS +: 32];
  assign f_pword     = cmd_q[PWORD_OFS +: 12];
  assign f_amp       = cmd_q[AMP_OFS +: 8];
  assign f_wave      = cmd_q[WAVE_OFS +: 2];
  assign f_out_en    = cmd_q[OUTEN_OFS];
  assign f_tag       = cmd_q[TAG_OFS +: 8];
  assign bad_cmd     = (f_cmd < CMD_WR_ALL) || (f_cmd > CMD_QUERY);
  assign bad_ch      = (f_chb >= 8'(NUM_CH));
  assign unused_bits = ^{cmd_q[PWORD_OFS+12 +: 4], cmd_q[WAVE_OFS+2 +: 5]};

  always_comb begin
    ld_fword = sh_fword[f_ch];
    ld_pword = sh_pword[f_ch];
    ld_amp   = sh_amp[f_ch];
    ld_wave  = sh_wave[f_ch];
    ld_en    = sh_en[f_ch];
    case (f_cmd)
      CMD_WR_ALL: begin
        ld_fword = f_fword;
        ld_pword = f_pword;
        ld_amp   = f_amp;
        ld_wave  = f_wave;
        ld_en    = f_out_en;
      end
      CMD_WR_FWORD: ld_fword = f_fword;
      CMD_WR_OUTEN: ld_en    = f_out_en;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    reply_set  = 1'b0;
    nak_take   = 1'b0;
    do_load    = 1'b0;
    do_tx      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    status_nxt = status_q;
    tag_nxt    = f_tag;
    case (state)
      ST_IDLE: begin
        if (nak_pend) begin
          reply_set  = 1'b1;
          nak_take   = 1'b1;
          status_nxt = STAT_OVF;
          tag_nxt    = nak_tag;
          state_nxt  = ST_TX0;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_TX0;
        reply_set = 1'b1;
        if (bad_cmd)                 status_nxt = STAT_BAD_CMD;
        else if (f_cmd == CMD_QUERY) status_nxt = 8'(fifo_lvl);
        else if (bad_ch)             status_nxt = STAT_BAD_CH;
        else begin
          reply_set = 1'b0;
          cnt_clr   = 1'b1;
          state_nxt = ST_WAIT_DDS;
        end
      end
      ST_WAIT_DDS: begin
        if (!dds_busy) begin
          do_load   = 1'b1;
          state_nxt = ST_LOAD;
        end else if (to_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          reply_set  = 1'b1;
          status_nxt = STAT_BUSY_TO;
          state_nxt  = ST_TX0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_LOAD: begin
        reply_set  = 1'b1;
        status_nxt = STAT_ACK;
        state_nxt  = ST_TX0;
      end
      ST_TX0, ST_TX1: begin
        if (!tx_busy) begin
          do_tx     = 1'b1;
          state_nxt = (state == ST_TX0) ? ST_TX0_W : ST_TX1_W;
        end
      end
      // Transmitter raises busy the cycle after tx_en; wait for the full pulse
      ST_TX0_W, ST_TX1_W: begin
        if (tx_seen && !tx_busy) state_nxt = (state == ST_TX0_W) ? ST_TX1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cmd_q      <= '0;
      status_q   <= '0;
      tag_q      <= '0;
      to_cnt     <= '0;
      tx_seen    <= 1'b0;
      nak_pend   <= 1'b0;
      nak_tag    <= '0;
      ovf_cnt    <= '0;
      cfg_ch     <= 1'b0;
      cfg_fword  <= '0;
      cfg_pword  <= '0;
      cfg_amp    <= '0;
      cfg_wave   <= '0;
      cfg_out_en <= 1'b0;
      cfg_load   <= 1'b0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_fword[i] <= '0;
        sh_pword[i] <= '0;
        sh_amp[i]   <= '0;
        sh_wave[i]  <= '0;
        sh_en[i]    <= 1'b0;
      end
    end else begin
      cfg_load <= do_load;
      tx_en    <= do_tx;
      if (pop) cmd_q <= fifo_dout;
      if (reply_set) begin
        status_q <= status_nxt;
        tag_q    <= tag_nxt;
      end
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + CNT_W'(1);
      if (do_tx)        tx_seen <= 1'b0;
      else if (tx_busy) tx_seen <= 1'b1;
      // A new drop wins over clearing, so the latest dropped tag is never lost
      if (drop) begin
        nak_pend <= 1'b1;
        nak_tag  <= frame_in[TAG_OFS +: 8];
        ovf_cnt  <= sat_inc8(ovf_cnt);
      end else if (nak_take) begin
        nak_pend <= 1'b0;
      end
      if (do_tx) tx_data <= (state == ST_TX1) ? tag_q : status_q;
      if (do_load) begin
        cfg_ch         <= f_ch;
        cfg_fword      <= ld_fword;
        cfg_pword      <= ld_pword;
        cfg_amp        <= ld_amp;
        cfg_wave       <= ld_wave;
        cfg_out_en     <= ld_en;
        sh_fword[f_ch] <= ld_fword;
        sh_pword[f_ch] <= ld_pword;
        sh_amp[f_ch]   <= ld_amp;
        sh_wave[f_ch]  <= ld_wave;
        sh_en[f_ch]    <= ld_en;
      end
    end
  end

endmodule

// File: doc/dds_cmd_sched.md
Name: dds_cmd_sched

Overview:
Command scheduler between the multi-byte UART frame receiver and the two-channel DDS core. It buffers validated 11-byte frames in a 4-deep command FIFO and decodes each command. Each decoded command is applied to the addressed DDS channel through a load handshake that respects the DDS busy signal. Every command, including a dropped one, is answered with a 2-byte status/tag reply through the UART transmitter.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2
BUSY_TIMEOUT, 50000, sys_clk cycles to wait for dds_busy low before NAK (1 ms at 50 MHz)
NUM_CH, 2, DDS channels addressed by the channel byte

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous reset, ACTIVE-HIGH despite the name; one clock only
recv_done  in  1  one-cycle pulse: rev_data0..rev_data10 hold a valid frame
rev_data0..rev_data10  in  8 each  frame payload; stable from recv_done until the next recv_done
cfg_ch  out  1  target channel of the current load
cfg_fword  out  32  frequency tuning word
cfg_pword  out  12  phase offset
cfg_amp  out  8  amplitude scale
cfg_wave  out  2  waveform select: 0 sine, 1 square, 2 triangle, 3 saw
cfg_out_en  out  1  channel output enable
cfg_load  out  1  one-cycle pulse; DDS captures all cfg_* on it
dds_busy  in  1  DDS cannot accept a load (phase-accumulator resync)
tx_data  out  8  reply byte to the UART transmitter
tx_en  out  1  one-cycle start pulse to the UART transmitter
tx_busy  in  1  transmitter busy
ovf_cnt  out  8  count of frames dropped on a full FIFO; saturates at 255
fifo_lvl  out  3  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Frame fields:
  - rev_data0 = cmd; rev_data1 = channel (bit0 used; a value >= NUM_CH gives NAK 0xE1).
  - rev_data2..5 = fword, big-endian.
  - {rev_data6[3:0], rev_data7} = pword.
  - rev_data8 = amp; rev_data9[1:0] = wave; rev_data9[7] = out_en.
  - rev_data10 = tag, echoed in the reply.
- Commands:
  - 0x01 writes all fields.
  - 0x02 writes fword only; the other fields come from the shadow registers.
  - 0x03 writes out_en only.
  - 0x04 is a status query: no load; the reply status is {5'b0, fifo_lvl}.
  - Any other cmd gives NAK 0xE0 and no load.
- Shadow registers: one set per channel (fword, pword, amp, wave, out_en). Updated only in the cycle cfg_load is issued.
- FIFO:
  - A recv_done pulse pushes the 88-bit frame.
  - When full, the frame is dropped, ovf_cnt increments, and a pending-NAK flag is set. The scheduler sends reply {0xE3, tag of the dropped frame} before its next pop. Only the latest dropped tag is kept.
  - A push and a pop in the same cycle on a full FIFO succeed; occupancy is unchanged and nothing is dropped.
- FSM states: IDLE, DECODE, WAIT_DDS, LOAD, TX0, TX0_W, TX1, TX1_W.
  - IDLE: if the pending-NAK flag is set, go to TX0 with status 0xE3. Otherwise, if the FIFO is non-empty, pop into the command register and go to DECODE.
  - DECODE (1 cycle): an invalid cmd or channel goes to TX0 with NAK; cmd 0x04 goes to TX0; otherwise go to WAIT_DDS and clear the timeout counter.
  - WAIT_DDS: while dds_busy=1, count. At BUSY_TIMEOUT-1, go to TX0 with status 0xE2 and no load. When dds_busy=0, go to LOAD.
  - LOAD: cfg_* driven and cfg_load=1 for exactly one cycle; shadow updated; then TX0 with status 0xA5 (ACK).
  - TX0: wait for tx_busy=0, then tx_data=status and tx_en=1 for one cycle, then go to TX0_W.
  - TX0_W: wait for tx_busy to rise, then fall (the transmitter asserts busy the cycle after tx_en). Then go to TX1.
  - TX1 / TX1_W: same sequence with tx_data=tag, then return to IDLE.
- Latency: from recv_done into an empty FIFO with dds_busy=0 to cfg_load is 4 cycles (push, pop, DECODE, WAIT_DDS, then LOAD).
- cfg_* hold their last driven values between loads. tx_data holds its last value.
- Reset values:
  - FSM in IDLE; FIFO empty; fifo_lvl=0; ovf_cnt=0.
  - All cfg_* = 0, cfg_load=0.
  - tx_data=0, tx_en=0.
  - Shadows = 0; pending-NAK cleared.
- Reset mid-operation: the FIFO is flushed, any in-flight command is abandoned without a reply, and no cfg_load or tx_en pulse is issued in the reset cycle.
- Only one command is in flight at a time. A recv_done arriving during any state is still pushed.

Decomposition:
- Package dds_cmd_pkg holds:
  - cmd codes 0x01–0x04;
  - status codes ACK 0xA5, E0 (bad cmd), E1 (bad channel), E2 (busy timeout), E3 (overflow);
  - FSM state encoding;
  - frame field bit offsets.
- Sub-module cmd_fifo: a synchronous FIFO, parameterised width/depth, with full, empty and level outputs. The FSM and the shadow registers stay in the top.

Test Plan:
- Cmd 0x01, ch 0, fword 0x0147AE14, pword 0x123, amp 0x80, wave 1, en 1, tag 0x3C, dds_busy=0 -> cfg_load pulse 4 cycles after recv_done with exactly those values; tx bytes 0xA5 then 0x3C.
- Cmd 0x01 on ch 1, then cmd 0x02 ch 1 fword 0x00000010 -> second load keeps the first command's pword/amp/wave/en; ch 0 shadows untouched.
- dds_busy held high for BUSY_TIMEOUT cycles -> no cfg_load; reply 0xE2, tag. Separately, busy released after 100 cycles -> load in the following cycle.
- With tx_busy=1 stalling, 6 back-to-back frames (tags 1..6) -> ovf_cnt=1 and fifo_lvl peaks at 4. Reply sequence: ACK 1, then E3 tag 6, then ACK 2, 3, 4, 5.
- Cmd 0x7F -> reply 0xE0; channel 0x02 -> reply 0xE1; cmd 0x04 with 2 frames queued -> status 0x02; none of these load.
- Assert sys_rst_n in WAIT_DDS with 3 frames queued -> next cycle fifo_lvl=0, cfg_*=0, no tx_en or cfg_load pulses afterwards until a new frame arrives.
